// File: rtl/trdb_bmap_unpacker_pkg.sv
// Shared definitions for the branch-map unpacker: default map length and FSM states.
package trdb_bmap_unpacker_pkg;

    // Maximum number of branches carried by one branch-map packet.
    localparam int BMAP_LEN = 31;

    // Unpacker states: waiting for a packet, or replaying its beats.
    typedef enum logic {
        BMAP_IDLE  = 1'b0,
        BMAP_DRAIN = 1'b1
    } bmap_state_e;

endpackage : trdb_bmap_unpacker_pkg

// File: rtl/trdb_bmap_unpacker.sv
// Branch-map unpacker: replays one branch-map packet (map bits + count) as a stream
// of per-branch outcome beats. Map bit 0 is the oldest branch; a map bit of 0 means
// taken, so the emitted taken flag is the inverse of the map bit.
module trdb_bmap_unpacker
    import trdb_bmap_unpacker_pkg::*;
#(
    parameter int BMAP_LEN = trdb_bmap_unpacker_pkg::BMAP_LEN,
    parameter int CNT_W    = $clog2(BMAP_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                bmap_valid_i,
    output logic                bmap_ready_o,
    input  logic [BMAP_LEN-1:0] bmap_i,
    input  logic [CNT_W-1:0]    bcount_i,
    output logic                branch_valid_o,
    input  logic                branch_ready_i,
    output logic                branch_taken_o,
    output logic                branch_last_o,
    output logic [CNT_W-1:0]    branch_idx_o,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BMAP_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Clamp an incoming branch count to the map length.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] b);
        return (b > MAX_CNT) ? MAX_CNT : b;
    endfunction

    // Count is out of range for the map it came with.
    function automatic logic count_overflow(input logic [CNT_W-1:0] b);
        return (b > MAX_CNT);
    endfunction

    bmap_state_e         state;
    logic [BMAP_LEN-1:0] sr_p1;
    logic [CNT_W-1:0]    rem_p1;
    logic [CNT_W-1:0]    idx_p1;
    logic                vld_p1;
    logic                taken_p1;
    logic                last_p1;
    logic                err_p1;

    logic                beat_fire;
    logic                accept;
    logic [CNT_W-1:0]    cnt_p0;

    // Handshake decode; ready may look through the last beat's handshake so that a
    // following packet is taken without a bubble.
    always_comb begin
        beat_fire    = vld_p1 && branch_ready_i;
        bmap_ready_o = rst_ni && !flush_i &&
                       ((state == BMAP_IDLE) || (beat_fire && last_p1));
        accept       = bmap_valid_i && bmap_ready_o;
        cnt_p0       = sat_count(bcount_i);
    end

    // ---- stage p0 -> p1: packet load, beat shifting, flush and reset ----
    // FSM plus shift/count/index registers; beats hold while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= BMAP_IDLE;
            sr_p1    <= '0;
            rem_p1   <= '0;
            idx_p1   <= '0;
            vld_p1   <= 1'b0;
            taken_p1 <= 1'b0;
            last_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else if (flush_i) begin
            state    <= BMAP_IDLE;
            sr_p1    <= '0;
            rem_p1   <= '0;
            idx_p1   <= '0;
            vld_p1   <= 1'b0;
            taken_p1 <= 1'b0;
            last_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            err_p1 <= accept && count_overflow(bcount_i);
            if (accept && (cnt_p0 != '0)) begin
                state    <= BMAP_DRAIN;
                vld_p1   <= 1'b1;
                taken_p1 <= !bmap_i[0];
                last_p1  <= (cnt_p0 == ONE);
                idx_p1   <= '0;
                sr_p1    <= bmap_i >> 1;
                rem_p1   <= cnt_p0 - ONE;
            end else if (beat_fire) begin
                if (last_p1) begin
                    state  <= BMAP_IDLE;
                    vld_p1 <= 1'b0;
                end else begin
                    taken_p1 <= !sr_p1[0];
                    sr_p1    <= sr_p1 >> 1;
                    idx_p1   <= idx_p1 + ONE;
                    last_p1  <= (rem_p1 == ONE);
                    if (rem_p1 != '0) begin
                        rem_p1 <= rem_p1 - ONE;
                    end
                end
            end
        end
    end

    assign branch_valid_o = vld_p1;
    assign branch_taken_o = taken_p1;
    assign branch_last_o  = last_p1;
    assign branch_idx_o   = idx_p1;
    assign err_o          = err_p1;

endmodule : trdb_bmap_unpacker
